// File: rtl/dc_cal_ctrl_pkg.sv
// dc_cal_ctrl_pkg: shared types and constants for the DC calibration loop.
// LFSR_LEN sets the default window length when not supplied by the build.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

package dc_cal_ctrl_pkg;

    localparam int DC_W = 18;
    localparam int WIN_LOG2_DEF = `LFSR_LEN;

    localparam logic signed [DC_W:0] DC_MAX = 19'sd131071;
    localparam logic signed [DC_W:0] DC_MIN = -19'sd131072;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_UPDATE,
        S_DONE,
        S_TRACK
    } cal_state_t;

    // Most negative code has no positive magnitude, so it never counts as good.
    function automatic logic in_tol(
        input logic signed [DC_W-1:0] a,
        input int tol
    );
        int v;
        v = int'(a);
        return (v != -131072) && (v <= tol) && (v >= -tol);
    endfunction

endpackage

// File: rtl/dc_cal_ctrl_if.sv
// dc_cal_ctrl_if: strobe, control, error input and result bundle.
// master drives the loop, slave is the calibration controller.
interface dc_cal_ctrl_if;
    import dc_cal_ctrl_pkg::*;

    logic                   clk_en;
    logic                   start;
    logic                   abort;
    logic signed [DC_W-1:0] acc_dc_err;
    logic                   err_hold;
    logic signed [DC_W-1:0] dc_corr;
    logic                   busy;
    logic                   done;
    logic                   converged;
    logic                   timeout;
    logic [7:0]             iter_count;

    modport master (
        output clk_en, start, abort, acc_dc_err,
        input  err_hold, dc_corr, busy, done,
        input  converged, timeout, iter_count
    );

    modport slave (
        input  clk_en, start, abort, acc_dc_err,
        output err_hold, dc_corr, busy, done,
        output converged, timeout, iter_count
    );

endinterface

// File: rtl/dc_cal_ctrl_dc_sat_step.sv
// dc_sat_step: nxt = sat18(cur - (acc >>> SHIFT)), evaluated at 19 bits.
// Reusable by any loop controller with a shifted-step update law.
module dc_sat_step
    import dc_cal_ctrl_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic signed [DC_W-1:0] cur,
    input  logic signed [DC_W-1:0] acc,
    output logic signed [DC_W-1:0] nxt
);

    logic signed [DC_W:0] cur_x;
    logic signed [DC_W:0] acc_x;
    logic signed [DC_W:0] step;
    logic signed [DC_W:0] diff;

    // Widen by one bit so the subtract cannot wrap, then clamp.
    always_comb begin
        cur_x = {cur[DC_W-1], cur};
        acc_x = {acc[DC_W-1], acc};
        step  = acc_x >>> SHIFT;
        diff  = cur_x - step;
        if (diff > DC_MAX)
            nxt = DC_MAX[DC_W-1:0];
        else if (diff < DC_MIN)
            nxt = DC_MIN[DC_W-1:0];
        else
            nxt = diff[DC_W-1:0];
    end

endmodule

// File: rtl/dc_cal_ctrl.sv
// dc_cal_ctrl: windowed DC offset calibration loop controller.
// Build option DC_CAL_TRACK_EN keeps the loop tracking after convergence.
module dc_cal_ctrl
    import dc_cal_ctrl_pkg::*;
#(
    parameter int WIN_LOG2     = WIN_LOG2_DEF,
    parameter int MU_SHIFT     = 2,
    parameter int TOL          = 16,
    parameter int CONV_WINDOWS = 3,
    parameter int MAX_ITER     = 64
) (
    input logic         clk,
    input logic         reset,
    dc_cal_ctrl_if.slave cal
);

    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
    localparam logic [7:0] CONV_N = 8'(CONV_WINDOWS);
    localparam logic [7:0] ITER_N = 8'(MAX_ITER);

    cal_state_t             state;
    logic [WIN_LOG2-1:0]    win_cnt;
    logic [7:0]             conv_cnt;
    logic [7:0]             conv_nxt;
    logic [7:0]             iter_q;
    logic [7:0]             iter_nxt;
    logic signed [DC_W-1:0] corr_q;
    logic signed [DC_W-1:0] corr_nxt;
    logic                   good;
    logic                   hold_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   conv_q;
    logic                   tout_q;
`ifdef DC_CAL_TRACK_EN
    logic                   trk_q;
`endif

    dc_sat_step #(.SHIFT(MU_SHIFT)) u_step (
        .cur (corr_q),
        .acc (cal.acc_dc_err),
        .nxt (corr_nxt)
    );

    // Counts for the window being closed by the current UPDATE.
    always_comb begin
        good     = in_tol(cal.acc_dc_err, TOL);
        iter_nxt = iter_q + 8'd1;
        conv_nxt = good ? conv_cnt + 8'd1 : 8'd0;
`ifdef DC_CAL_TRACK_EN
        if (trk_q && iter_q == 8'hFF)
            iter_nxt = iter_q;
        if (trk_q && good && conv_cnt == CONV_N)
            conv_nxt = conv_cnt;
`endif
    end

    // Calibration sequencer with registered outputs; abort overrides all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            win_cnt  <= '0;
            conv_cnt <= '0;
            iter_q   <= '0;
            corr_q   <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            tout_q   <= 1'b0;
`ifdef DC_CAL_TRACK_EN
            trk_q    <= 1'b0;
`endif
        end else begin
            hold_q <= 1'b0;
            if (cal.abort && busy_q) begin
                hold_q <= 1'b1;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                conv_q <= 1'b0;
                tout_q <= 1'b0;
                state  <= S_IDLE;
`ifdef DC_CAL_TRACK_EN
                trk_q  <= 1'b0;
`endif
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (cal.start && !cal.abort) begin
                            iter_q   <= '0;
                            conv_cnt <= '0;
                            done_q   <= 1'b0;
                            conv_q   <= 1'b0;
                            tout_q   <= 1'b0;
                            hold_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        win_cnt <= '0;
                        state   <= S_ACCUM;
                    end
`ifdef DC_CAL_TRACK_EN
                    S_TRACK: begin
                        win_cnt <= '0;
                        state   <= S_ACCUM;
                    end
`endif
                    S_ACCUM: begin
                        if (cal.clk_en) begin
                            if (win_cnt == WIN_LAST)
                                state <= S_SETTLE;
                            else
                                win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cal.clk_en)
                            state <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        corr_q   <= corr_nxt;
                        iter_q   <= iter_nxt;
                        conv_cnt <= conv_nxt;
`ifdef DC_CAL_TRACK_EN
                        if (trk_q || conv_nxt == CONV_N) begin
                            trk_q  <= 1'b1;
                            done_q <= 1'b1;
                            conv_q <= (conv_nxt == CONV_N);
                            hold_q <= 1'b1;
                            state  <= S_TRACK;
                        end else
`else
                        if (conv_nxt == CONV_N) begin
                            conv_q <= 1'b1;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_DONE;
                        end else
`endif
                        if (iter_nxt == ITER_N) begin
                            tout_q <= 1'b1;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            hold_q <= 1'b1;
                            state  <= S_CLEAR;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign cal.err_hold   = hold_q;
    assign cal.dc_corr    = corr_q;
    assign cal.busy       = busy_q;
    assign cal.done       = done_q;
    assign cal.converged  = conv_q;
    assign cal.timeout    = tout_q;
    assign cal.iter_count = iter_q;

endmodule

// File: doc/dc_cal_ctrl.md
Name: dc_cal_ctrl

Overview:
- Sequences the DC-error accumulator through fixed-length measurement windows.
- After each window, reads the window-mean DC error and applies a shifted, saturated step to a DC correction register that feeds the front-end offset subtractor.
- Stops when the error stays within tolerance for several consecutive windows, or when the iteration limit is reached.
- Sits between the slicer-error path (err_dc_gen) and the front-end offset adder.

Parameters:
- WIN_LOG2, default `LFSR_LEN: window length is 2^WIN_LOG2 symbol strobes; must match the accumulator's shift.
- MU_SHIFT, default 2: step = acc >>> MU_SHIFT, arithmetic shift.
- TOL, default 16: convergence tolerance; a window is in tolerance when |acc| <= TOL.
- CONV_WINDOWS, default 3: number of consecutive in-tolerance windows required to declare convergence.
- MAX_ITER, default 64: maximum number of windows before timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- clk_en  in  1  symbol strobe, same strobe as the accumulator
- start  in  1  1-clk pulse; starts calibration; ignored while busy
- abort  in  1  1-clk pulse; cancels calibration
- acc_dc_err  in  18 signed  window-mean error from accumulator output
- err_hold  out  1  clears the accumulator; 1-clk pulse
- dc_corr  out  18 signed  DC correction value
- busy  out  1  high from start until DONE/IDLE
- done  out  1  level; set at end of calibration, cleared on start
- converged  out  1  level; convergence result
- timeout  out  1  level; MAX_ITER reached without convergence
- iter_count  out  8  windows completed in the current run

Behaviour:
- Reset values: all outputs 0; state IDLE; window counter 0; convergence counter 0.
- State IDLE: on start, clear iter_count/done/converged/timeout, go to CLEAR. dc_corr is retained across runs.
- State CLEAR (1 clk, not strobe-gated):
  - err_hold=1.
  - Window counter cleared.
  - Go to ACCUM.
- State ACCUM:
  - Count clk_en strobes.
  - On the strobe where count == 2^WIN_LOG2-1, go to SETTLE.
- State SETTLE: wait one further clk_en strobe, then go to UPDATE. This covers the accumulator's registered output latency.
- State UPDATE (1 clk): sample acc_dc_err.
  - dc_corr <= sat18(dc_corr - (acc >>> MU_SHIFT)), computed at 19 bits and clamped to [-131072, 131071].
  - iter_count increments.
  - If |acc| <= TOL, increment the convergence counter; otherwise clear it to 0.
  - |-131072| is treated as out of tolerance.
- Exit checks after UPDATE, in priority order:
  - Convergence counter == CONV_WINDOWS: converged=1, done=1, go to DONE.
  - Else iter_count == MAX_ITER: timeout=1, done=1, go to DONE.
  - Else go to CLEAR.
- State DONE: busy=0. Flags hold. start goes to IDLE actions, then CLEAR.
- busy = 1 in CLEAR, ACCUM, SETTLE and UPDATE.
- abort in any busy state:
  - err_hold=1 that clk.
  - Next state IDLE; busy=0.
  - dc_corr keeps its last committed value.
  - done/converged/timeout stay 0.
  - abort has priority over all transitions.
- start and abort in the same clk: abort wins.
- start while busy: ignored.
- clk_en low indefinitely: the FSM stalls in ACCUM/SETTLE. No watchdog.
- Reset mid-operation: immediate return to reset values, including dc_corr=0.

Optional Feature:
- Macro DC_CAL_TRACK_EN.
- Defined:
  - After convergence, done=1 and converged=1 are set, but the FSM enters TRACK instead of DONE.
  - TRACK repeats CLEAR/ACCUM/SETTLE/UPDATE indefinitely with the same update law; busy stays 1.
  - iter_count saturates at 255.
  - No timeout in TRACK.
  - converged drops to 0 on any out-of-tolerance window and re-asserts after CONV_WINDOWS good windows.
  - Only abort or reset exits TRACK.
- Undefined: behaviour as above; no TRACK state is synthesized.

Decomposition:
- Shared package/defines (defines.vh):
  - state encoding constants IDLE/CLEAR/ACCUM/SETTLE/UPDATE/DONE/TRACK;
  - DC_W=18;
  - DC_MAX/DC_MIN saturation constants;
  - default window tied to `LFSR_LEN.
- One natural sub-module: dc_sat_step, combinational subtract-shift-saturate, reusable by other loop controllers.

Test Plan:
All scenarios use WIN_LOG2=4, clk_en every 4th clk, and the bench drives acc_dc_err.
1. Reset asserted mid-ACCUM -> all outputs 0, err_hold 0, busy 0 on the same edge.
2. start, acc=400 constant -> err_hold pulses 1 clk at each window start; first UPDATE occurs 17 strobes after CLEAR; dc_corr = -100, then -200, -300.
3. acc=10 constant -> converged=1, done=1 after 3 windows; dc_corr=-6; iter_count=3; busy falls the next clk.
4. acc=1000 constant -> timeout=1 after 64 windows; dc_corr=-16000; converged=0.
5. MU_SHIFT=0, dc_corr preloaded to 0 by reset, acc=-131072 -> dc_corr=131071 (saturated), not wrapped.
6. abort at strobe 7 of window 2, with start in the same clk -> err_hold=1, busy=0 next clk, dc_corr equals its value after window 1, done=0.
